// File: rtl/nand_reduce_pipe.sv
// nand_reduce_pipe: per-lane AND/NAND/OR/NOR/XOR/XNOR reduction through a
// registered binary tree, with a valid/ready handshake and a global stall.
// Ports: clk, rst (async, active high).
//   Producer side: in_valid, in_ready, in_data (lane k = [k*WIDTH +: WIDTH]),
//   in_mode (0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6-7 reserved).
//   Consumer side: out_valid, out_ready, out_data (bit k = lane k),
//   out_err (result came from a reserved mode).
module nand_reduce_pipe #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [2:0]                in_mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS-1:0]       out_data,
    output logic                      out_err
);

    localparam int LEVELS  = $clog2(WIDTH);
    localparam int LATENCY = (LEVELS < 1) ? 1 : LEVELS;
    localparam int CW      = CHANNELS * WIDTH;

    // Number of live operands per lane after s pairing levels.
    function automatic int lvl_n(input int s);
        int n;
        n = WIDTH;
        for (int i = 0; i < s; i++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

    // Base operator; inversion is applied only at the last stage.
    function automatic logic op2(
        input logic       x,
        input logic       y,
        input logic [2:0] m
    );
        logic r;
        r = x ^ y;
        unique case (1'b1)
            (m[2:1] == 2'd0): r = x & y;
            (m[2:1] == 2'd1): r = x | y;
            default:          r = x ^ y;
        endcase
        return r;
    endfunction

    // One tree level on every lane: operand j of the result combines
    // operands 2j and 2j+1; an unpaired last operand passes through.
    // Bits at and above the live count stay zero.
    function automatic logic [CW-1:0] fold(
        input logic [CW-1:0] a,
        input int            n,
        input logic [2:0]    m
    );
        logic [CW-1:0] r;
        logic [WIDTH:0] sh;
        r = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            for (int j = 0; j < WIDTH; j++) begin
                sh = {1'b0, a[k*WIDTH +: WIDTH]} >> (2 * j);
                if (2 * j + 1 < n) begin
                    r[k*WIDTH + j] = op2(sh[0], sh[1], m);
                end else if (2 * j < n) begin
                    r[k*WIDTH + j] = sh[0];
                end
            end
        end
        return r;
    endfunction

    logic [CW-1:0]       stg_dat  [LATENCY];
    logic [2:0]          stg_mode [LATENCY];
    logic                stg_vld  [LATENCY];
    logic [CW-1:0]       lvl      [LATENCY];
    logic [CW-1:0]       dat_q    [LATENCY];
    logic [2:0]          mode_q   [LATENCY];
    logic                vld_q    [LATENCY];
    logic [CHANNELS-1:0] out_q;
    logic [CHANNELS-1:0] res_d;
    logic                err_q;
    logic                err_d;
    logic                ovld_q;
    logic                adv;

    assign adv       = ~ovld_q | out_ready;
    assign in_ready  = adv;
    assign out_valid = ovld_q;
    assign out_data  = out_q;
    assign out_err   = err_q;

    // Stage i consumes the raw input (i = 0) or the previous register.
    always_comb begin
        stg_dat[0]  = in_data;
        stg_mode[0] = in_mode;
        stg_vld[0]  = in_valid;
        for (int i = 1; i < LATENCY; i++) begin
            stg_dat[i]  = dat_q[i-1];
            stg_mode[i] = mode_q[i-1];
            stg_vld[i]  = vld_q[i-1];
        end
    end

    for (genvar g = 0; g < LATENCY; g++) begin : g_lvl
        assign lvl[g] = fold(stg_dat[g], lvl_n(g), stg_mode[g]);
    end

    // Final stage: odd modes invert, reserved modes force 0 and flag.
    always_comb begin
        res_d = '0;
        err_d = (stg_mode[LATENCY-1] > 3'd5);
        for (int k = 0; k < CHANNELS; k++) begin
            res_d[k] = err_d ? 1'b0
                     : (lvl[LATENCY-1][k*WIDTH] ^ stg_mode[LATENCY-1][0]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i]  <= '0;
                mode_q[i] <= '0;
                vld_q[i]  <= 1'b0;
            end
            out_q  <= '0;
            err_q  <= 1'b0;
            ovld_q <= 1'b0;
        end else if (adv) begin
            for (int i = 0; i < LATENCY - 1; i++) begin
                dat_q[i]  <= lvl[i];
                mode_q[i] <= stg_mode[i];
                vld_q[i]  <= stg_vld[i];
            end
            out_q  <= res_d;
            err_q  <= err_d;
            ovld_q <= stg_vld[LATENCY-1];
        end
    end

endmodule

// File: tb/tb_nand_reduce_pipe.sv
// tb_nand_reduce_pipe: self-checking bench for nand_reduce_pipe.
// Instance a: WIDTH=4, CHANNELS=2. Instance b: WIDTH=5, CHANNELS=1.
module tb_nand_reduce_pipe;

    logic       clk = 1'b0;
    logic       rst;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
    logic [7:0] a_in_data;
    logic [2:0] a_in_mode;
    logic [1:0] a_out_data;

    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
    logic [4:0] b_in_data;
    logic [2:0] b_in_mode;
    logic [0:0] b_out_data;

    int n_chk  = 0;
    int n_fail = 0;

    logic [2:0] qa [$];
    logic [1:0] qb [$];
    logic       a_hold = 1'b0;
    logic [1:0] a_hold_val;
    logic       a_hold_err;
    logic       b_hold = 1'b0;
    logic [0:0] b_hold_val;

    typedef struct {
        logic [2:0] mode;
        logic [7:0] data;
        logic [1:0] exp;
        logic       err;
    } vec_t;
    vec_t tbl [12];

    always #5 clk = ~clk;

    nand_reduce_pipe #(.WIDTH(4), .CHANNELS(2)) u_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .in_mode   (a_in_mode),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .out_err   (a_out_err)
    );

    nand_reduce_pipe #(.WIDTH(5), .CHANNELS(1)) u_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_mode   (b_in_mode),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_err   (b_out_err)
    );

    // Flat reference reduction from the population count of the lane.
    function automatic logic ref_red(
        input logic [63:0] v,
        input int          w,
        input logic [2:0]  m
    );
        int ones;
        ones = 0;
        for (int i = 0; i < w; i++) ones += int'(v[i]);
        case (m)
            3'd0:    return ones == w;
            3'd1:    return ones != w;
            3'd2:    return ones != 0;
            3'd3:    return ones == 0;
            3'd4:    return ones[0];
            3'd5:    return !ones[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] a_model(input logic [7:0] d, input logic [2:0] m);
        return {m > 3'd5, ref_red(64'(d[7:4]), 4, m), ref_red(64'(d[3:0]), 4, m)};
    endfunction

    function automatic logic [1:0] b_model(input logic [4:0] d, input logic [2:0] m);
        return {m > 3'd5, ref_red(64'(d), 5, m)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic a_cyc(input logic v, input logic [7:0] d, input logic [2:0] m,
                         input logic r);
        logic [2:0] e;
        @(negedge clk);
        if (a_hold) begin
            chk("a_hold_data", 64'(a_out_data), 64'(a_hold_val));
            chk("a_hold_err", 64'(a_out_err), 64'(a_hold_err));
        end
        a_in_valid  = v;
        a_in_data   = d;
        a_in_mode   = m;
        a_out_ready = r;
        #1;
        a_hold = a_out_valid && !a_out_ready;
        if (a_hold) begin
            a_hold_val = a_out_data;
            a_hold_err = a_out_err;
            chk("a_stall_in_ready", 64'(a_in_ready), 0);
        end
        if (a_out_valid && a_out_ready) begin
            chk("a_result_expected", 64'(qa.size() != 0), 1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                chk("a_sb_data", 64'(a_out_data), 64'(e[1:0]));
                chk("a_sb_err", 64'(a_out_err), 64'(e[2]));
            end
        end
        if (a_in_valid && a_in_ready) qa.push_back(a_model(a_in_data, a_in_mode));
    endtask

    task automatic b_cyc(input logic v, input logic [4:0] d, input logic [2:0] m,
                         input logic r);
        logic [1:0] e;
        @(negedge clk);
        if (b_hold) chk("b_hold_data", 64'(b_out_data), 64'(b_hold_val));
        b_in_valid  = v;
        b_in_data   = d;
        b_in_mode   = m;
        b_out_ready = r;
        #1;
        b_hold = b_out_valid && !b_out_ready;
        if (b_hold) begin
            b_hold_val = b_out_data;
            chk("b_stall_in_ready", 64'(b_in_ready), 0);
        end
        if (b_out_valid && b_out_ready) begin
            chk("b_result_expected", 64'(qb.size() != 0), 1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                chk("b_sb_data", 64'(b_out_data), 64'(e[0]));
                chk("b_sb_err", 64'(b_out_err), 64'(e[1]));
            end
        end
        if (b_in_valid && b_in_ready) qb.push_back(b_model(b_in_data, b_in_mode));
    endtask

    // Isolated transaction: checks the two-stage latency and the table value.
    task automatic a_single(input int idx);
        a_cyc(1'b1, tbl[idx].data, tbl[idx].mode, 1'b1);
        chk("a_accept_ready", 64'(a_in_ready), 1);
        a_cyc(1'b0, 8'h00, 3'd0, 1'b1);
        chk("a_lat_early", 64'(a_out_valid), 0);
        a_cyc(1'b0, 8'h00, 3'd0, 1'b1);
        chk("a_lat_valid", 64'(a_out_valid), 1);
        chk("a_tbl_data", 64'(a_out_data), 64'(tbl[idx].exp));
        chk("a_tbl_err", 64'(a_out_err), 64'(tbl[idx].err));
        a_cyc(1'b0, 8'h00, 3'd0, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic r;
        tbl[0]  = '{3'd1, 8'hFF, 2'b00, 1'b0};
        tbl[1]  = '{3'd1, 8'hEE, 2'b11, 1'b0};
        tbl[2]  = '{3'd1, 8'hF7, 2'b01, 1'b0};
        tbl[3]  = '{3'd3, 8'h0F, 2'b10, 1'b0};
        tbl[4]  = '{3'd4, 8'h69, 2'b00, 1'b0};
        tbl[5]  = '{3'd6, 8'hFF, 2'b00, 1'b1};
        tbl[6]  = '{3'd0, 8'hFF, 2'b11, 1'b0};
        tbl[7]  = '{3'd2, 8'h10, 2'b10, 1'b0};
        tbl[8]  = '{3'd5, 8'h13, 2'b01, 1'b0};
        tbl[9]  = '{3'd7, 8'h00, 2'b00, 1'b1};
        tbl[10] = '{3'd0, 8'h7F, 2'b01, 1'b0};
        tbl[11] = '{3'd3, 8'h00, 2'b11, 1'b0};

        rst = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0; a_in_mode = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_in_mode = '0; b_out_ready = 1'b1;
        #12;
        chk("rst_a_out_valid", 64'(a_out_valid), 0);
        chk("rst_a_out_data", 64'(a_out_data), 0);
        chk("rst_a_out_err", 64'(a_out_err), 0);
        chk("rst_a_in_ready", 64'(a_in_ready), 1);
        chk("rst_b_out_valid", 64'(b_out_valid), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) a_single(i);

        // Back-to-back stream: one result per cycle, in order.
        for (int i = 0; i < 14; i++) begin
            if (i < 12) a_cyc(1'b1, tbl[i].data, tbl[i].mode, 1'b1);
            else        a_cyc(1'b0, 8'h00, 3'd0, 1'b1);
            if (i < 12) chk("a_b2b_ready", 64'(a_in_ready), 1);
            if (i >= 2) begin
                chk("a_b2b_valid", 64'(a_out_valid), 1);
                chk("a_b2b_data", 64'(a_out_data), 64'(tbl[i-2].exp));
                chk("a_b2b_err", 64'(a_out_err), 64'(tbl[i-2].err));
            end
        end
        a_cyc(1'b0, 8'h00, 3'd0, 1'b1);
        chk("a_b2b_empty", 64'(a_out_valid), 0);

        // Backpressure: consumer stalls 4 cycles while the producer pushes.
        for (int i = 0; i < 12; i++) begin
            r = !(i >= 3 && i < 7);
            a_cyc(1'b1, 8'($urandom), 3'($urandom_range(0, 5)), r);
            if (!r) chk("a_bp_in_ready", 64'(a_in_ready), 0);
        end
        for (int i = 0; i < 4; i++) a_cyc(1'b0, 8'h00, 3'd0, 1'b1);
        chk("a_bp_drained", 64'(qa.size()), 0);

        // Asynchronous reset with two transactions in flight.
        a_cyc(1'b1, 8'hFF, 3'd0, 1'b1);
        a_cyc(1'b1, 8'h00, 3'd3, 1'b1);
        @(negedge clk);
        a_in_valid = 1'b0;
        #1;
        chk("a_pre_rst_valid", 64'(a_out_valid), 1);
        chk("a_pre_rst_data", 64'(a_out_data), 2'b11);
        rst = 1'b1;
        #1;
        chk("a_rst_valid", 64'(a_out_valid), 0);
        chk("a_rst_data", 64'(a_out_data), 0);
        chk("a_rst_err", 64'(a_out_err), 0);
        qa.delete();
        a_hold = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_cyc(1'b0, 8'h00, 3'd0, 1'b1);
            chk("a_no_stale", 64'(a_out_valid), 0);
        end
        a_single(6);

        // Random traffic on instance a.
        for (int i = 0; i < 300; i++) begin
            a_cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom),
                  1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 4; i++) a_cyc(1'b0, 8'h00, 3'd0, 1'b1);
        chk("a_rand_drained", 64'(qa.size()), 0);

        // WIDTH=5: every vector under every valid mode, then random traffic.
        for (int m = 0; m < 6; m++) begin
            for (int v = 0; v < 32; v++) b_cyc(1'b1, 5'(v), 3'(m), 1'b1);
        end
        for (int i = 0; i < 200; i++) begin
            b_cyc(1'($urandom_range(0, 3) != 0), 5'($urandom), 3'($urandom),
                  1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 6; i++) b_cyc(1'b0, 5'd0, 3'd0, 1'b1);
        chk("b_drained", 64'(qb.size()), 0);
        chk("b_idle", 64'(b_out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
